// File: rtl/column_msg_page_writer.sv
// column_msg_page_writer
//   Takes one column of shifted messages (all stride units, all bit-planes)
//   per col_valid/col_ready handshake. The column goes into a two-slot
//   ping-pong store. It is then written out as STRIDE_WIDTH message-memory
//   pages, one stride unit per page per cycle. col_done pulses once when the
//   last page of a column has been written.
//
// Ports
//   sys_clk, rstn      clock (rising edge), asynchronous active-low reset
//   col_valid/ready    column handshake; col_ready depends only on buffer occupancy
//   col_msg_i          column data, stride s page at [s*PAGE_W +: PAGE_W]
//   col_base_addr_i    base address of the column, captured with the data
//   mem_we/mem_stall   page write valid / memory back-pressure
//   mem_addr/wdata     page address (base + page index, wraps) and page data
//   col_done           one-cycle pulse after the last page of a column is written
//   mem_wpar           even parity of mem_wdata (only when PAGE_PARITY_EN is defined)
//
// Optional feature macro: PAGE_PARITY_EN
module column_msg_page_writer #(
  parameter  int QUAN_SIZE        = 4,
  parameter  int STRIDE_UNIT_SIZE = 15,
  parameter  int STRIDE_WIDTH     = 3,
  parameter  int ADDR_WIDTH       = 8,
  localparam int PAGE_W           = QUAN_SIZE * STRIDE_UNIT_SIZE,
  localparam int COL_W            = STRIDE_WIDTH * PAGE_W
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  col_valid,
  output logic                  col_ready,
  input  logic [COL_W-1:0]      col_msg_i,
  input  logic [ADDR_WIDTH-1:0] col_base_addr_i,
  output logic                  mem_we,
  input  logic                  mem_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [PAGE_W-1:0]     mem_wdata,
  output logic                  col_done
`ifdef PAGE_PARITY_EN
  ,
  output logic                  mem_wpar
`endif
);

  localparam int PIDX_W = (STRIDE_WIDTH > 1) ? $clog2(STRIDE_WIDTH) : 1;
  localparam logic [PIDX_W-1:0] LAST_PAGE = PIDX_W'(STRIDE_WIDTH - 1);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [PIDX_W-1:0]     page_idx_q, page_idx_d;
  logic                  col_done_q, col_done_d;
  logic [COL_W-1:0]      slot_data_q [2];
  logic [COL_W-1:0]      slot_data_d [2];
  logic [ADDR_WIDTH-1:0] slot_base_q [2];
  logic [ADDR_WIDTH-1:0] slot_base_d [2];

  logic                  accept;
  logic                  retire;
  logic                  rel_col;
  logic [PAGE_W-1:0]     page_sel;

  always_comb begin
    accept  = col_valid && (count_q != 2'd2);
    retire  = (state_q == WRITE) && !mem_stall;
    rel_col = retire && (page_idx_q == LAST_PAGE);

    slot_data_d = slot_data_q;
    slot_base_d = slot_base_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    state_d     = state_q;
    page_idx_d  = page_idx_q;
    col_done_d  = rel_col;
    count_d     = count_q + 2'(accept) - 2'(rel_col);

    if (accept) begin
      slot_data_d[wr_sel_q] = col_msg_i;
      slot_base_d[wr_sel_q] = col_base_addr_i;
      wr_sel_d              = ~wr_sel_q;
    end
    if (rel_col) begin
      rd_sel_d = ~rd_sel_q;
    end

    // count_d already includes a same-cycle accept. A column captured at
    // this edge therefore starts writing on the very next cycle. A release
    // that coincides with an accept also continues with no bubble.
    case (state_q)
      IDLE: begin
        if (count_d != 2'd0) begin
          state_d    = WRITE;
          page_idx_d = '0;
        end
      end
      WRITE: begin
        if (rel_col) begin
          page_idx_d = '0;
          state_d    = (count_d != 2'd0) ? WRITE : IDLE;
        end else if (retire) begin
          page_idx_d = page_idx_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        page_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      page_idx_q <= '0;
      col_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      page_idx_q <= page_idx_d;
      col_done_q <= col_done_d;
    end
  end

  // Slot payload is never consumed before it has been written, so it needs no reset.
  always_ff @(posedge sys_clk) begin
    slot_data_q <= slot_data_d;
    slot_base_q <= slot_base_d;
  end

  // Page outputs are a mux of flops gated by state. There is no path from
  // mem_stall or col_valid, and a stalled page holds because its selects are frozen.
  always_comb begin
    page_sel  = slot_data_q[rd_sel_q][int'(page_idx_q)*PAGE_W +: PAGE_W];
    mem_we    = (state_q == WRITE);
    mem_wdata = mem_we ? page_sel : '0;
    mem_addr  = mem_we ? (slot_base_q[rd_sel_q] + ADDR_WIDTH'(page_idx_q)) : '0;
    col_ready = (count_q != 2'd2);
    col_done  = col_done_q;
  end

`ifdef PAGE_PARITY_EN
  assign mem_wpar = ^mem_wdata;
`endif

endmodule

// File: tb/tb_column_msg_page_writer.sv
module tb_column_msg_page_writer;
  localparam int PAGE_W = 60;
  localparam int COL_W  = 180;

  logic              sys_clk = 1'b0;
  logic              rstn;
  logic              col_valid;
  logic              col_ready;
  logic [COL_W-1:0]  col_msg_i;
  logic [7:0]        col_base_addr_i;
  logic              mem_we;
  logic              mem_stall;
  logic [7:0]        mem_addr;
  logic [PAGE_W-1:0] mem_wdata;
  logic              col_done;
`ifdef PAGE_PARITY_EN
  logic              mem_wpar;
`endif

  column_msg_page_writer #(
    .QUAN_SIZE(4), .STRIDE_UNIT_SIZE(15), .STRIDE_WIDTH(3), .ADDR_WIDTH(8)
  ) dut (
    .sys_clk(sys_clk), .rstn(rstn), .col_valid(col_valid), .col_ready(col_ready),
    .col_msg_i(col_msg_i), .col_base_addr_i(col_base_addr_i), .mem_we(mem_we),
    .mem_stall(mem_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .col_done(col_done)
`ifdef PAGE_PARITY_EN
    , .mem_wpar(mem_wpar)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0]        addr;
    logic [PAGE_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  logic exp_done = 1'b0;
  int   we_run = 0;
  int   max_run = 0;
  int   last_done_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  // Monitor: sample at negedge, when inputs and outputs are stable.
  always @(negedge sys_clk) begin : monitor
    logic ret_last;
    logic acc;
    if (!rstn) begin
      sbq.delete();
      model_cnt = 0;
      exp_done  = 1'b0;
      we_run    = 0;
    end else begin
      ret_last = 1'b0;
      check("col_ready", 64'(col_ready), 64'(model_cnt != 2));
      if (col_done || exp_done) check("col_done", 64'(col_done), 64'(exp_done));
      if (col_done) last_done_cyc = cyc;
      if (mem_we) begin
        we_run++;
        if (we_run > max_run) max_run = we_run;
        if (sbq.size() == 0) begin
          check("unexpected_we", 64'(1), 64'(0));
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(sbq[0].addr));
          check("mem_wdata", 64'(mem_wdata), 64'(sbq[0].data));
`ifdef PAGE_PARITY_EN
          check("mem_wpar", 64'(mem_wpar), 64'(^sbq[0].data));
`endif
          if (!mem_stall) begin
            ret_last = sbq[0].last;
            void'(sbq.pop_front());
          end
        end
      end else begin
        we_run = 0;
        check("idle_addr", 64'(mem_addr), 64'(0));
        check("idle_wdata", 64'(mem_wdata), 64'(0));
`ifdef PAGE_PARITY_EN
        check("idle_wpar", 64'(mem_wpar), 64'(0));
`endif
      end
      acc = col_valid && (model_cnt != 2);
      model_cnt = model_cnt + int'(acc) - int'(ret_last);
      exp_done  = ret_last;
    end
  end

  // Push the three expected pages, present the column, and return at
  // posedge+1 right after the capture edge. col_valid is left asserted.
  task automatic send_col(input logic [7:0] base, input logic [PAGE_W-1:0] p0,
                          input logic [PAGE_W-1:0] p1, input logic [PAGE_W-1:0] p2);
    exp_t e;
    bit   got;
    got = 1'b0;
    e.addr = base;         e.data = p0; e.last = 1'b0; sbq.push_back(e);
    e.addr = base + 8'd1;  e.data = p1; e.last = 1'b0; sbq.push_back(e);
    e.addr = base + 8'd2;  e.data = p2; e.last = 1'b1; sbq.push_back(e);
    col_msg_i       = {p2, p1, p0};
    col_base_addr_i = base;
    col_valid       = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge sys_clk);
      got = col_ready;
      @(posedge sys_clk);
      #1;
    end
    if (!got) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle();
    col_valid = 1'b0;
    col_msg_i = '0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge sys_clk);
      #1;
      ok = (sbq.size() == 0) && !mem_we;
    end
    if (!ok) check("drain_timeout", 64'(0), 64'(1));
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_addr(input logic [7:0] a);
    bit ok;
    ok = mem_we && (mem_addr == a);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge sys_clk);
      #1;
      ok = mem_we && (mem_addr == a);
    end
    if (!ok) check("addr_wait_timeout", 64'(0), 64'(1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    rstn = 1'b0; col_valid = 1'b0; mem_stall = 1'b0;
    col_msg_i = '0; col_base_addr_i = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_col_ready", 64'(col_ready), 64'(1));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_col_done", 64'(col_done), 64'(0));
    rstn = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // Single column: pages zeros/ones/zeros at 0x10..0x12.
    send_col(8'h10, '0, '1, '0);
    k = cyc;
    check("latency_first_we", 64'(mem_we), 64'(1));
    idle();
    wait_drain();
    check("done_latency", 64'(last_done_cyc), 64'(k + 3));

    // Back-to-back columns with col_valid held high: 9 pages, no bubble.
    max_run = 0;
    send_col(8'h80, 60'h0123456789ABCDE, 60'hFEDCBA987654321, 60'h5A5A5A5A5A5A5A5);
    send_col(8'h83, 60'hA5A5A5A5A5A5A5A, 60'h000000000000001, 60'h800000000000000);
    send_col(8'h86, 60'hCAFEBABEDEADBEE, 60'h0F0F0F0F0F0F0F0, 60'h123123123123123);
    idle();
    wait_drain();
    check("b2b_run", 64'(max_run), 64'(9));

    // Four stall cycles on page 1.
    send_col(8'h20, 60'h111111111111111, 60'h222222222222222, 60'h333333333333333);
    k = cyc;
    idle();
    @(posedge sys_clk);
    #1;
    check("stall_page1_addr", 64'(mem_addr), 64'(8'h21));
    mem_stall = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    mem_stall = 1'b0;
    wait_drain();
    check("stall_done_latency", 64'(last_done_cyc), 64'(k + 7));

    // Address wrap; pages also carry 7 ones, all zeros, and 2 ones for parity.
    send_col(8'hFE, 60'h00000000000007F, 60'h000000000000000, 60'h000000000000003);
    idle();
    wait_drain();

    // Reset during page 1 of a two-column backlog.
    send_col(8'h40, 60'h444444444444444, 60'h454545454545454, 60'h464646464646464);
    send_col(8'h50, 60'h555555555555555, 60'h565656565656565, 60'h575757575757575);
    idle();
    wait_addr(8'h41);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_mem_we", 64'(mem_we), 64'(0));
    check("midrst_col_ready", 64'(col_ready), 64'(1));
    check("midrst_mem_addr", 64'(mem_addr), 64'(0));
    check("midrst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("midrst_col_done", 64'(col_done), 64'(0));
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge sys_clk);
    #1;
    send_col(8'h60, 60'h666666666666666, 60'h676767676767676, 60'h686868686868686);
    idle();
    wait_drain();

    check("queue_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/column_msg_page_writer.md
# column_msg_page_writer

Downstream stage of the column-wise L1 circular-shift route. Accepts one column's shifted messages (all stride units, all bit-planes) per handshake, double-buffers them in a two-slot ping-pong store, and serialises them into message-memory write pages, one stride unit per page per cycle. It decouples the combinational shifter output from memory back-pressure and flags column completion to the layer scheduler.

## Interface
- QUAN_SIZE, 4: message bit-planes per stride unit.
- STRIDE_UNIT_SIZE, 15: messages per stride unit (shifter length).
- STRIDE_WIDTH, 3: stride units per column.
- ADDR_WIDTH, 8: message-memory address width.
- Derived (localparam): PAGE_W = QUAN_SIZE*STRIDE_UNIT_SIZE; COL_W = STRIDE_WIDTH*PAGE_W.
- sys_clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- col_valid  in  1  column data valid from L1 route stage.
- col_ready  out  1  block can accept a column this cycle.
- col_msg_i  in  COL_W  shifted messages; stride s, bit-plane q at [s*PAGE_W + q*STRIDE_UNIT_SIZE +: STRIDE_UNIT_SIZE].
- col_base_addr_i  in  ADDR_WIDTH  memory base address of this column, captured with the data.
- mem_we  out  1  page write valid.
- mem_stall  in  1  memory cannot take a write this cycle.
- mem_addr  out  ADDR_WIDTH  page address.
- mem_wdata  out  PAGE_W  page data; bit-plane q at [q*STRIDE_UNIT_SIZE +: STRIDE_UNIT_SIZE].
- col_done  out  1  one-cycle pulse: last page of a column written.
- mem_wpar  out  1  even parity of mem_wdata (only with PAGE_PARITY_EN).

## Operation
- Storage: two slots {data COL_W, base ADDR_WIDTH}; write pointer wr_sel, read pointer rd_sel, occupancy count 0..2.
- Accept: col_valid & col_ready at edge -> data and base into slot wr_sel; wr_sel toggles; count+1.
- col_ready = (count != 2), driven from registered count only (no combinational path from mem_stall or col_valid).
- Drain FSM: IDLE, WRITE.
  - IDLE: mem_we=0. If count>0 -> WRITE, page_idx=0.
  - WRITE: mem_we=1; mem_wdata = slot[rd_sel].data[page_idx*PAGE_W +: PAGE_W]; mem_addr = slot[rd_sel].base + page_idx, modulo 2^ADDR_WIDTH (wrap, no carry out).
  - Page retired on mem_we & !mem_stall. While stalled, mem_addr/mem_wdata/page_idx hold stable.
  - Retire with page_idx < STRIDE_WIDTH-1 -> page_idx+1.
  - Retire with page_idx = STRIDE_WIDTH-1 -> slot released (count-1, rd_sel toggles), col_done=1 next cycle; stay in WRITE with page_idx=0 if another slot is occupied (including one accepted this same cycle), else IDLE.
- Simultaneous accept and release: count unchanged; both pointers update.
- Steady-state throughput: one column per STRIDE_WIDTH cycles, no bubbles between columns.
- col_valid while col_ready=0: ignored, no capture; upstream must hold.

## Timing
- Reset (rstn low, asynchronous): count=0, wr_sel=rd_sel=0, page_idx=0, state IDLE; outputs col_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, col_done=0, mem_wpar=0. Slot data need not be cleared.
- Reset mid-column: buffered columns discarded, no col_done issued.
- Latency: column captured at edge k -> first mem_we high in cycle k+1; last page (no stall) in cycle k+STRIDE_WIDTH; col_done high in cycle k+STRIDE_WIDTH+1 for exactly one cycle.
- Each stall cycle delays all later pages and col_done by one cycle.
- col_ready reasserts the cycle after the release edge when count was 2.

## Configuration
- PAGE_PARITY_EN defined: mem_wpar port present, registered/aligned with mem_wdata, equal to XOR of all PAGE_W bits of the currently driven page; 0 while mem_we=0.
- Undefined: mem_wpar port and logic absent; all other behaviour identical.

## Test plan
- Single column, no stall: base=0x10, stride s page = {PAGE_W{s[0]}} pattern -> mem_we 3 cycles, addr 0x10,0x11,0x12, data zeros/ones/zeros, col_done one cycle after the 0x12 page.
- Back-to-back columns, col_valid held high, no stall -> 6 consecutive mem_we cycles, col_ready drops to 0 exactly when count=2, no lost or duplicated page.
- mem_stall high for 4 cycles on page 1 -> addr/data held stable throughout, page 1 written once, col_done delayed by 4 cycles.
- Address wrap: base=0xFE, ADDR_WIDTH=8 -> addresses 0xFE, 0xFF, 0x00.
- Reset asserted during page 1 of a two-column backlog -> outputs at reset values immediately, col_ready=1, no col_done after release; new column then writes normally.
- PAGE_PARITY_EN: page with 7 ones -> mem_wpar=1; all-zero page -> mem_wpar=0.
